// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple adder.
// Segment sizing lives here so the top and any wrapper agree on the split.
package adder_pkg;

    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell built from plain XOR/majority logic.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder_aoi.sv
// One-bit full adder cell in AND-OR-INVERT form: the inverted carry is reused to form the sum.
module full_adder_aoi (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic co_n;

    assign co_n = ~((a & b) | (ci & (a | b)));
    assign sum  = ((a | b | ci) & co_n) | (a & b & ci);
    assign co   = ~co_n;

endmodule

// File: rtl/pra_segment.sv
// Combinational SEG-bit ripple segment; also exposes the carry into its MSB for overflow detection.
module pra_segment #(
    parameter int SEG     = 16,
    parameter int USE_AOI = 0
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co,
    output logic           cmsb
);

    logic [SEG:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        if (USE_AOI != 0) begin : g_aoi
            full_adder_aoi u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (c[i]),
                .sum(sum[i]),
                .co (c[i+1])
            );
        end else begin : g_plain
            full_adder u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (c[i]),
                .sum(sum[i]),
                .co (c[i+1])
            );
        end
    end

    assign co   = c[SEG];
    assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, carry registered
// between stages, global stall when the consumer back-pressures a valid result.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int STAGES  = 4,
    parameter int USE_AOI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_ripple_adder: WIDTH=%0d must split evenly into 1..WIDTH stages, got STAGES=%0d",
               WIDTH, STAGES);
    end

    // a_hi/b_hi carry the not-yet-added upper operand slices; sum_lo collects finished slices.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic             cmsb;
    } stage_t;

    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic             c0;
    stage_t           last;

    assign b_cond = sub ? ~in2 : in2;
    assign c0     = sub ? 1'b1 : ci;

    // Global stall: every stage moves only when the output slot is free or being drained.
    assign adv      = !last.valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         stage_in;
        stage_t         stage_d;
        stage_t         stage_q;
        logic [SEG-1:0] seg_sum;
        logic           seg_co;
        logic           seg_cmsb;

        if (k == 0) begin : g_entry
            // NOTE: every field gets a default before selective overrides, so no latch is inferred.
            always_comb begin
                stage_in       = '0;
                stage_in.valid = in_valid;
                stage_in.a_hi  = in1;
                stage_in.b_hi  = b_cond;
                stage_in.carry = c0;
            end
        end else begin : g_link
            assign stage_in = g_stage[k-1].stage_q;
        end

        pra_segment #(
            .SEG    (SEG),
            .USE_AOI(USE_AOI)
        ) u_seg (
            .a   (stage_in.a_hi[k*SEG +: SEG]),
            .b   (stage_in.b_hi[k*SEG +: SEG]),
            .ci  (stage_in.carry),
            .sum (seg_sum),
            .co  (seg_co),
            .cmsb(seg_cmsb)
        );

        always_comb begin
            stage_d                      = stage_in;
            stage_d.sum_lo[k*SEG +: SEG] = seg_sum;
            stage_d.carry                = seg_co;
            stage_d.cmsb                 = seg_cmsb;
        end

        // NOTE: pipeline registers are reset (non-blocking, async) so sum/co/ovf read 0, never X,
        // until the first real op arrives; bubbles only clear valid and leave the payload alone.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else if (adv) begin
                if (stage_in.valid) begin
                    stage_q <= stage_d;
                end else begin
                    stage_q.valid <= 1'b0;
                end
            end
        end
    end

    assign last      = g_stage[STAGES-1].stage_q;
    assign out_valid = last.valid;
    assign sum       = last.sum_lo;
    assign co        = last.carry;
    assign ovf       = last.cmsb ^ last.carry;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed corner cases, streaming,
// stall, random flow control and mid-stream reset against an arithmetic reference model.
module tb_pipelined_ripple_adder #(
    parameter int W       = 64,
    parameter int STAGES  = 4,
    parameter int USE_AOI = 0
);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic         acc;
        logic         ret;
        logic         valid;
        logic         ready;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } obs_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pipelined_ripple_adder #(
        .WIDTH  (W),
        .STAGES (STAGES),
        .USE_AOI(USE_AOI)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .ci       (ci),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .co       (co),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain (W+1)-bit arithmetic, overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        logic [W:0] wide;
        res_t       r;
        if (s) begin
            wide  = {1'b0, a} - {1'b0, b};
            r.co  = ~wide[W];
            r.ovf = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
        end else begin
            wide  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            r.co  = wide[W];
            r.ovf = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
        end
        r.sum = wide[W-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return '0;
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic drive_op(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        in_valid = v;
        in1      = a;
        in2      = b;
        ci       = c;
        sub      = s;
    endtask

    task automatic drive_random(input logic v);
        drive_op(v, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Samples on the falling edge, then returns 1 time unit after the next rising edge.
    task automatic tick(output obs_t o);
        @(negedge clk);
        o.acc   = in_valid && in_ready;
        o.ret   = out_valid && out_ready;
        o.valid = out_valid;
        o.ready = in_ready;
        o.sum   = sum;
        o.co    = co;
        o.ovf   = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive_op(1'b0, '0, '0, 1'b0, 1'b0);
        #12;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if ({sum, co, ovf} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got sum=%h co=%b ovf=%b want all 0", sum, co, ovf);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6], tb[6], es[6];
        logic         tc[6], ts[6], eco[6], eov[6];
        obs_t         o;
        int           lat;
        bit           seen;
        ta[0] = '1;                     tb[0] = W'(1); tc[0] = 0; ts[0] = 0;
        es[0] = '0;                     eco[0] = 1;    eov[0] = 0;
        ta[1] = W'(5);                  tb[1] = W'(7); tc[1] = 0; ts[1] = 1;
        es[1] = ~W'(1);                 eco[1] = 0;    eov[1] = 0;
        ta[2] = W'(7);                  tb[2] = W'(5); tc[2] = 0; ts[2] = 1;
        es[2] = W'(2);                  eco[2] = 1;    eov[2] = 0;
        ta[3] = {1'b0, {(W-1){1'b1}}};  tb[3] = W'(1); tc[3] = 0; ts[3] = 0;
        es[3] = {1'b1, {(W-1){1'b0}}};  eco[3] = 0;    eov[3] = 1;
        ta[4] = W'(3);                  tb[4] = W'(4); tc[4] = 1; ts[4] = 0;
        es[4] = W'(8);                  eco[4] = 0;    eov[4] = 0;
        ta[5] = W'(9);                  tb[5] = W'(9); tc[5] = 1; ts[5] = 1;
        es[5] = '0;                     eco[5] = 1;    eov[5] = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, ta[i], tb[i], tc[i], ts[i]);
            tick(o);
            drive_op(1'b0, '0, '0, 1'b0, 1'b0);
            total++;
            if (!o.acc) begin
                bad++;
                $display("FAIL directed_accept[%0d]: got ready=%b want 1", i, o.ready);
            end
            lat  = 0;
            seen = 0;
            while (!seen && lat < 4 * STAGES + 4) begin
                tick(o);
                lat++;
                seen = o.valid;
            end
            total++;
            if (!seen || lat != STAGES) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got %0d (seen=%0d) want %0d", i, lat, seen, STAGES);
            end
            total++;
            if ({o.sum, o.co, o.ovf} !== {es[i], eco[i], eov[i]}) begin
                bad++;
                $display("FAIL directed_result[%0d]: got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                         i, o.sum, o.co, o.ovf, es[i], eco[i], eov[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        res_t e;
        res_t hold;
        int   sent = 0;
        int   cyc  = 0;
        out_ready = 1'b1;
        while (sent < 100 && cyc < 200) begin
            drive_random(1'b1);
            tick(o);
            if (o.acc) begin
                exp_q.push_back(model(in1, in2, ci, sub));
                sent++;
            end
            total++;
            if (o.ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_in_ready: got %b want 1 at cycle %0d", o.ready, cyc);
            end
            if (cyc >= STAGES) begin
                total++;
                if (!o.ret) begin
                    bad++;
                    $display("FAIL b2b_throughput: got no result want one at cycle %0d", cyc);
                end
            end
            if (o.ret) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: got sum=%h want no result", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.sum, o.co, o.ovf} !== e) begin
                        bad++;
                        $display("FAIL b2b_result: got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                                 o.sum, o.co, o.ovf, e.sum, e.co, e.ovf);
                    end
                end
            end
            cyc++;
        end

        // Pipe is full; hold the consumer off for 5 cycles with a new op waiting.
        out_ready = 1'b0;
        drive_random(1'b1);
        hold = '0;
        for (int i = 0; i < 5; i++) begin
            tick(o);
            total++;
            if (o.ready !== 1'b0 || o.acc) begin
                bad++;
                $display("FAIL stall_in_ready: got %b want 0 at stall cycle %0d", o.ready, i);
            end
            total++;
            if (i == 0) begin
                hold = {o.sum, o.co, o.ovf};
                if (!o.valid || exp_q.size() == 0 || hold !== exp_q[0]) begin
                    bad++;
                    $display("FAIL stall_front: got valid=%b sum=%h want queued head (size %0d)",
                             o.valid, o.sum, exp_q.size());
                end
            end else if (!o.valid || {o.sum, o.co, o.ovf} !== hold) begin
                bad++;
                $display("FAIL stall_stable: got valid=%b sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                         o.valid, o.sum, o.co, o.ovf, hold.sum, hold.co, hold.ovf);
            end
        end

        out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() > 0 || cyc == 0) && cyc < 4 * STAGES + 8) begin
            tick(o);
            if (cyc == 0) begin
                if (o.acc) exp_q.push_back(model(in1, in2, ci, sub));
                drive_op(1'b0, '0, '0, 1'b0, 1'b0);
            end
            if (o.ret) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL drain_extra: got sum=%h want no result", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.sum, o.co, o.ovf} !== e) begin
                        bad++;
                        $display("FAIL drain_result: got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                                 o.sum, o.co, o.ovf, e.sum, e.co, e.ovf);
                    end
                end
            end
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        for (int i = 0; i < STAGES + 2; i++) begin
            tick(o);
            total++;
            if (o.valid !== 1'b0) begin
                bad++;
                $display("FAIL drain_duplicate: got out_valid=%b want 0", o.valid);
            end
        end
    endtask

    task automatic test_random_flow();
        obs_t o;
        obs_t prev;
        logic prev_stalled = 1'b0;
        res_t e;
        int   cyc = 0;
        prev = '0;
        for (int i = 0; i < 300 + 4 * STAGES + 8; i++) begin
            if (i < 300) begin
                if (!(in_valid && prev_stalled)) drive_random($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                drive_op(1'b0, '0, '0, 1'b0, 1'b0);
                out_ready = 1'b1;
            end
            tick(o);
            if (o.acc) exp_q.push_back(model(in1, in2, ci, sub));
            total++;
            if (o.ready !== (!o.valid || out_ready)) begin
                bad++;
                $display("FAIL flow_ready: got %b want %b", o.ready, !o.valid || out_ready);
            end
            if (prev_stalled) begin
                total++;
                if (!o.valid || {o.sum, o.co, o.ovf} !== {prev.sum, prev.co, prev.ovf}) begin
                    bad++;
                    $display("FAIL flow_hold: got valid=%b sum=%h want held sum=%h", o.valid, o.sum, prev.sum);
                end
            end
            if (o.ret) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL flow_extra: got sum=%h want no result", o.sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.sum, o.co, o.ovf} !== e) begin
                        bad++;
                        $display("FAIL flow_result: got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                                 o.sum, o.co, o.ovf, e.sum, e.co, e.ovf);
                    end
                end
            end
            prev_stalled = o.valid && !out_ready;
            prev = o;
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL flow_lost: got %0d outstanding after %0d cycles want 0", exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midstream();
        obs_t o;
        out_ready = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) begin
            drive_random(1'b1);
            tick(o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if ({sum, co, ovf} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got sum=%h co=%b ovf=%b want all 0", sum, co, ovf);
        end
        exp_q.delete();
        drive_op(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2 * STAGES + 4; i++) begin
            tick(o);
            total++;
            if (o.valid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_stale: got out_valid=%b sum=%h want no result", o.valid, o.sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_flow();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
